lc3bp_dmem_wait: RTL and testbench
==================================

# lc3bp_dmem_wait

Parametrised, synthesizable LC-3b data-memory model for the 5-stage pipeline's MEM stage. It replaces the always-ready single-word stand-in with a byte-lane-writable RAM of configurable depth and base address. It adds a programmable wait-state handshake on `dcache_r`, so the pipeline's memory-stall path is exercised. It sits between `LC3BP_TOP_FULL`'s `dcache_*` port group and the system bench or FPGA top.

## Interface

Parameters:
- `ADDR_W`, default 10: word-address bits. Depth is 2^ADDR_W 16-bit words.
- `BASE_ADDR`, default 16'h0000: byte address of word 0. Must be word-aligned.
- `WAIT_CYCLES`, default 4, range 0..15: extra cycles between request acceptance and `dcache_r`.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `dcache_en`, in, 1: access request. The requester holds it high until `dcache_r`.
- `dcache_we`, in, 2: byte write enables. [0] is the low byte, [1] is the high byte; 00 means read.
- `dcache_addr`, in, 16: byte address. Bit 0 is ignored.
- `dcache_din`, in, 16: write data.
- `dcache_dout`, out, 16: read data. Valid only while `dcache_r` is 1.
- `dcache_r`, out, 1: ready/done pulse, one cycle wide.
- `dcache_oor`, out, 1: out-of-range flag. Same timing as `dcache_r`.
- `rd_count`, `wr_count`, out, 16 each: present only under `LC3BP_DMEM_STATS_EN`.

## Operation

- FSM states are IDLE, WAIT and DONE.
- **IDLE**
  - If `dcache_en` is 1, latch addr/we/din and load the wait counter with WAIT_CYCLES.
  - Go to DONE if WAIT_CYCLES is 0, otherwise go to WAIT.
- **WAIT**
  - Decrement the counter each cycle; at 1, go to DONE.
  - If `dcache_en` drops, abort: return to IDLE, do not write, do not pulse `dcache_r`.
- **DONE**
  - Assert `dcache_r`.
  - Read: drive `dcache_dout` with the latched word.
  - Write: commit enabled lanes on this clock edge. Disabled lanes keep their old value.
  - Always return to IDLE.
- Word index is `(addr_latched - BASE_ADDR) >> 1`. The result is in range if it is below 2^ADDR_W.
- Out of range:
  - Read returns 16'h0000.
  - Write is dropped.
  - `dcache_oor` is 1 alongside `dcache_r`.
- Addresses are latched at acceptance. Later changes to addr/we/din during WAIT are ignored.
- A read after a write to the same word in the next request returns the new data.
- RAM contents are not reset.

## Timing

- Reset values:
  - FSM in IDLE.
  - `dcache_r`, `dcache_oor` = 0.
  - `dcache_dout` = 16'h0000.
  - Counters = 0.
- Latency is WAIT_CYCLES + 1 cycles from the edge that samples `dcache_en`=1 to `dcache_r`=1.
- Minimum request spacing is WAIT_CYCLES + 2 cycles, because of the mandatory IDLE cycle after DONE. A request still asserted in that IDLE cycle is treated as a new request.
- `dcache_dout` is registered and returns to 0 the cycle after DONE.
- Reset asserted mid-WAIT or in DONE: the FSM goes to IDLE immediately, the pending write is lost, and `dcache_r` goes low asynchronously.

## Configuration

`LC3BP_DMEM_STATS_EN`:
- **Defined:** `rd_count` and `wr_count` ports exist.
  - Each increments by 1 on every DONE read or write, in range or not.
  - Both saturate at 16'hFFFF and reset to 0.
  - Aborted requests are not counted.
- **Undefined:** the ports and the counter logic are absent. All other behaviour is identical.

## Structure

- Package `lc3bp_mem_pkg` holds:
  - the `dmem_state_t` enum (IDLE/WAIT/DONE);
  - `localparam` `WE_READ=2'b00`, `WE_LO=2'b01`, `WE_HI=2'b10`, `WE_WORD=2'b11`;
  - the 16-bit `word_t` typedef.
- Sub-module `lc3bp_bwram`: a 2^ADDR_W x 16 synchronous RAM with 2 byte-write enables. The FSM, counter and range check stay in `lc3bp_dmem_wait`.

## Test plan

- **Word write/read:** WAIT_CYCLES=4. STW of 16'h0005 to 0x0000, then LDW from 0x0000. Expect:
  - `dcache_r` exactly 5 cycles after each `dcache_en` rise;
  - read data 16'h0005.
- **Byte lanes:** write 16'hABCD with we=11 to 0x0010, then 16'h1200 with we=10. A word read returns 16'h12CD.
- **Zero wait and back-to-back:** WAIT_CYCLES=0, two reads with `dcache_en` held high. `dcache_r` pulses at cycles 1 and 3 with an IDLE gap.
- **Abort and reset:**
  - Drop `dcache_en` in the 2nd WAIT cycle of a write of 16'h7777: no `dcache_r`, memory unchanged.
  - Pull `rst_n` low mid-WAIT: `dcache_r`=0 at once and the FSM is in IDLE.
- **Range:** BASE_ADDR=16'h4000, ADDR_W=4.
  - Write to 0x4020: `dcache_oor`=1, write dropped.
  - Read from 0x401E: `dcache_oor`=0.
  - Read from 0x3FFE: returns 0 with `dcache_oor`=1.
- **Stats (macro on):** 3 reads and 2 writes, one of them aborted. Expect `rd_count`/`wr_count` equal to the completed reads and writes; preload 16'hFFFF and confirm saturation.

Source files
------------

// File: rtl/lc3bp_mem_pkg.sv
// rtl/lc3bp_mem_pkg.sv - shared state, word type and write-enable encodings for the LC-3b data memory
package lc3bp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  typedef logic [15:0] word_t;

  localparam logic [1:0] WE_READ = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

endpackage

// File: rtl/lc3bp_bwram.sv
// rtl/lc3bp_bwram.sv - 2^ADDR_W x 16 synchronous RAM with per-byte write enables
module lc3bp_bwram
  import lc3bp_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output word_t             rdata,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  word_t             wdata
);

  word_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if ((we & WE_LO) != WE_READ) mem[waddr][7:0]  <= wdata[7:0];
    if ((we & WE_HI) != WE_READ) mem[waddr][15:8] <= wdata[15:8];
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lc3bp_dmem_wait.sv
// rtl/lc3bp_dmem_wait.sv - wait-state data memory for the LC-3b MEM stage
// Optional access counters rd_count/wr_count under LC3BP_DMEM_STATS_EN.
module lc3bp_dmem_wait
  import lc3bp_mem_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dcache_en,
  input  logic [1:0]  dcache_we,
  input  logic [15:0] dcache_addr,
  input  logic [15:0] dcache_din,
  output logic [15:0] dcache_dout,
  output logic        dcache_r,
  output logic        dcache_oor
`ifdef LC3BP_DMEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic [15:0]       addr_q;
  logic [1:0]        we_q;
  word_t             din_q;
  word_t             ram_q;
  logic [15:0]       rd_off;
  logic [15:0]       acc_off;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] acc_idx;
  logic              ram_re;
  logic              in_range;
  logic              is_read;
  logic              commit;

  // The RAM is read at acceptance so the word is ready even with zero wait states.
  assign rd_off   = dcache_addr - BASE_ADDR;
  assign acc_off  = addr_q - BASE_ADDR;
  assign rd_idx   = ADDR_W'(rd_off >> 1);
  assign acc_idx  = ADDR_W'(acc_off >> 1);
  assign in_range = (acc_off >> (ADDR_W + 1)) == 16'h0000;
  assign is_read  = (we_q == WE_READ);
  assign ram_re   = (state == IDLE) && dcache_en;
  assign commit   = (state == DONE) && !is_read && in_range;

  lc3bp_bwram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .raddr (rd_idx),
    .rdata (ram_q),
    .we    (commit ? we_q : WE_READ),
    .waddr (acc_idx),
    .wdata (din_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      addr_q      <= 16'h0000;
      we_q        <= WE_READ;
      din_q       <= 16'h0000;
      dcache_r    <= 1'b0;
      dcache_oor  <= 1'b0;
      dcache_dout <= 16'h0000;
    end else begin
      dcache_r    <= 1'b0;
      dcache_oor  <= 1'b0;
      dcache_dout <= 16'h0000;
      unique case (state)
        IDLE: begin
          if (dcache_en) begin
            addr_q <= dcache_addr;
            we_q   <= dcache_we;
            din_q  <= dcache_din;
            cnt    <= WAIT_INIT;
            state  <= (WAIT_INIT == 4'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!dcache_en) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= DONE;
          end
        end
        DONE: begin
          dcache_r   <= 1'b1;
          dcache_oor <= !in_range;
          if (is_read && in_range) dcache_dout <= ram_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LC3BP_DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else if (state == DONE) begin
      if (is_read) begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end else if (wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lc3bp_dmem_wait.sv
// tb/tb_lc3bp_dmem_wait.sv - self-checking bench for lc3bp_dmem_wait (three parameter sets)
// Counter checks are compiled in under LC3BP_DMEM_STATS_EN.
module tb_lc3bp_dmem_wait;
  import lc3bp_mem_pkg::*;

  typedef struct {
    int          k;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic        exp_oor;
    bit          wiggle;
    string       nm;
  } vec_t;

  typedef struct {
    int          k;
    logic [15:0] dout;
    logic        oor;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en   [3];
  logic [1:0]  we   [3];
  logic [15:0] addr [3];
  logic [15:0] din  [3];
  logic [15:0] dout [3];
  logic        r    [3];
  logic        oor  [3];
  logic        prev_r [3] = '{default: 1'b0};
`ifdef LC3BP_DMEM_STATS_EN
  logic [15:0] rd_cnt [3];
  logic [15:0] wr_cnt [3];
  int          rd_model [3] = '{default: 0};
  int          wr_model [3] = '{default: 0};
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb [$];
  exp_t mon_e;
  vec_t tv [$];

  always #5 clk = ~clk;

  // k=0: defaults; k=1: zero wait; k=2: small window based at 0x4000
  lc3bp_dmem_wait u_w4 (
    .clk(clk), .rst_n(rst_n), .dcache_en(en[0]), .dcache_we(we[0]),
    .dcache_addr(addr[0]), .dcache_din(din[0]), .dcache_dout(dout[0]),
    .dcache_r(r[0]), .dcache_oor(oor[0])
`ifdef LC3BP_DMEM_STATS_EN
    , .rd_count(rd_cnt[0]), .wr_count(wr_cnt[0])
`endif
  );

  lc3bp_dmem_wait #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .dcache_en(en[1]), .dcache_we(we[1]),
    .dcache_addr(addr[1]), .dcache_din(din[1]), .dcache_dout(dout[1]),
    .dcache_r(r[1]), .dcache_oor(oor[1])
`ifdef LC3BP_DMEM_STATS_EN
    , .rd_count(rd_cnt[1]), .wr_count(wr_cnt[1])
`endif
  );

  lc3bp_dmem_wait #(.ADDR_W(4), .BASE_ADDR(16'h4000), .WAIT_CYCLES(2)) u_rng (
    .clk(clk), .rst_n(rst_n), .dcache_en(en[2]), .dcache_we(we[2]),
    .dcache_addr(addr[2]), .dcache_din(din[2]), .dcache_dout(dout[2]),
    .dcache_r(r[2]), .dcache_oor(oor[2])
`ifdef LC3BP_DMEM_STATS_EN
    , .rd_count(rd_cnt[2]), .wr_count(wr_cnt[2])
`endif
  );

  function automatic int wait_of(input int k);
    case (k)
      0:       return 4;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  function automatic vec_t v(input int k, input logic [1:0] w, input logic [15:0] a,
                             input logic [15:0] d, input logic [15:0] ed, input logic eo,
                             input bit wig, input string nm);
    vec_t t;
    t.k = k; t.we = w; t.addr = a; t.din = d;
    t.exp_dout = ed; t.exp_oor = eo; t.wiggle = wig; t.nm = nm;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [15:0] d, input logic o);
    exp_t e;
    e.k = k; e.dout = d; e.oor = o;
    sb.push_back(e);
  endtask

  task automatic count_done(input int k, input logic [1:0] w);
`ifdef LC3BP_DMEM_STATS_EN
    if (w == WE_READ) begin
      if (rd_model[k] < 16'hFFFF) rd_model[k]++;
    end else if (wr_model[k] < 16'hFFFF) begin
      wr_model[k]++;
    end
`else
    if (k < 0 || w == 2'bxx) $display("unreachable");
`endif
  endtask

  task automatic clear_models();
`ifdef LC3BP_DMEM_STATS_EN
    for (int k = 0; k < 3; k++) begin
      rd_model[k] = 0;
      wr_model[k] = 0;
    end
`endif
  endtask

  // Called at a negedge; returns at the negedge where dcache_r is seen.
  task automatic access(input vec_t t);
    int lat;
    push_exp(t.k, t.exp_dout, t.exp_oor);
    en[t.k] = 1'b1; we[t.k] = t.we; addr[t.k] = t.addr; din[t.k] = t.din;
    @(posedge clk);
    if (t.wiggle) begin
      @(negedge clk);
      we[t.k] = WE_READ; addr[t.k] = t.addr + 16'h0010; din[t.k] = 16'h9999;
    end
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!r[t.k] && lat < 40);
    en[t.k] = 1'b0; we[t.k] = WE_READ;
    check({t.nm, "_latency"}, lat, wait_of(t.k) + 1);
    count_done(t.k, t.we);
  endtask

  // Scoreboard: every dcache_r pulse consumes the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n && prev_r[k]) check($sformatf("dout_clear_%0d", k), dout[k], 16'h0000);
      if (rst_n && r[k]) begin
        if (sb.size() == 0) begin
          check($sformatf("unexpected_r_%0d", k), 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("sb_inst_%0d", k), k, mon_e.k);
          check($sformatf("sb_dout_%0d", k), dout[k], mon_e.dout);
          check($sformatf("sb_oor_%0d", k), oor[k], mon_e.oor);
        end
      end
      prev_r[k] = r[k];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int pulses;
    logic [4:0] pat;
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0; we[k] = WE_READ; addr[k] = 16'h0000; din[k] = 16'h0000;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_r_%0d", k), r[k], 1'b0);
      check($sformatf("rst_oor_%0d", k), oor[k], 1'b0);
      check($sformatf("rst_dout_%0d", k), dout[k], 16'h0000);
`ifdef LC3BP_DMEM_STATS_EN
      check($sformatf("rst_rdcnt_%0d", k), rd_cnt[k], 16'h0000);
      check($sformatf("rst_wrcnt_%0d", k), wr_cnt[k], 16'h0000);
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);

    tv.push_back(v(0, WE_WORD, 16'h0000, 16'h0005, 16'h0000, 1'b0, 1'b0, "stw_0000"));
    tv.push_back(v(0, WE_READ, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b0, "ldw_0000"));
    tv.push_back(v(0, WE_WORD, 16'h0800, 16'hFFFF, 16'h0000, 1'b1, 1'b0, "stw_past_top"));
    tv.push_back(v(0, WE_READ, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b0, "ldw_0000_again"));
    tv.push_back(v(0, WE_WORD, 16'h0010, 16'hABCD, 16'h0000, 1'b0, 1'b0, "stw_abcd"));
    tv.push_back(v(0, WE_HI,   16'h0010, 16'h1200, 16'h0000, 1'b0, 1'b0, "stb_hi"));
    tv.push_back(v(0, WE_READ, 16'h0010, 16'h0000, 16'h12CD, 1'b0, 1'b0, "ldw_lanes"));
    tv.push_back(v(0, WE_LO,   16'h0011, 16'h00EF, 16'h0000, 1'b0, 1'b0, "stb_lo_odd"));
    tv.push_back(v(0, WE_READ, 16'h0011, 16'h0000, 16'h12EF, 1'b0, 1'b0, "ldw_odd"));
    tv.push_back(v(0, WE_WORD, 16'h0020, 16'h1111, 16'h0000, 1'b0, 1'b0, "stw_0020"));
    tv.push_back(v(0, WE_WORD, 16'h07FE, 16'hBEEF, 16'h0000, 1'b0, 1'b0, "stw_top"));
    tv.push_back(v(0, WE_READ, 16'h07FE, 16'h0000, 16'hBEEF, 1'b0, 1'b0, "ldw_top"));
    tv.push_back(v(0, WE_READ, 16'h0800, 16'h0000, 16'h0000, 1'b1, 1'b0, "ldw_past_top"));
    tv.push_back(v(0, WE_WORD, 16'h0030, 16'h4242, 16'h0000, 1'b0, 1'b1, "stw_wiggle"));
    tv.push_back(v(0, WE_READ, 16'h0030, 16'h0000, 16'h4242, 1'b0, 1'b0, "ldw_wiggle"));
    tv.push_back(v(1, WE_WORD, 16'h0002, 16'hC0DE, 16'h0000, 1'b0, 1'b0, "w0_stw"));
    tv.push_back(v(1, WE_READ, 16'h0002, 16'h0000, 16'hC0DE, 1'b0, 1'b0, "w0_ldw"));
    tv.push_back(v(2, WE_WORD, 16'h4000, 16'h1234, 16'h0000, 1'b0, 1'b0, "rng_stw_base"));
    tv.push_back(v(2, WE_WORD, 16'h401E, 16'h5A5A, 16'h0000, 1'b0, 1'b0, "rng_stw_last"));
    tv.push_back(v(2, WE_WORD, 16'h4020, 16'hDEAD, 16'h0000, 1'b1, 1'b0, "rng_stw_over"));
    tv.push_back(v(2, WE_READ, 16'h4000, 16'h0000, 16'h1234, 1'b0, 1'b0, "rng_ldw_base"));
    tv.push_back(v(2, WE_READ, 16'h401E, 16'h0000, 16'h5A5A, 1'b0, 1'b0, "rng_ldw_last"));
    tv.push_back(v(2, WE_READ, 16'h3FFE, 16'h0000, 16'h0000, 1'b1, 1'b0, "rng_ldw_under"));

    for (int i = 0; i < tv.size(); i++) begin
      access(tv[i]);
      @(negedge clk);
    end

    // Zero wait, en held: pulses after edges 1 and 3 of the burst.
    push_exp(1, 16'hC0DE, 1'b0);
    push_exp(1, 16'hC0DE, 1'b0);
    en[1] = 1'b1; we[1] = WE_READ; addr[1] = 16'h0002;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      pat[i] = r[1];
      if (i == 2) en[1] = 1'b0;
    end
    check("b2b_pattern", pat, 5'b00101);
    count_done(1, WE_READ);
    count_done(1, WE_READ);
    @(negedge clk);

    // Abort in the second wait cycle of a write.
    en[0] = 1'b1; we[0] = WE_WORD; addr[0] = 16'h0020; din[0] = 16'h7777;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    en[0] = 1'b0; we[0] = WE_READ;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (r[0]) pulses++;
    end
    check("abort_no_r", pulses, 0);
    access(v(0, WE_READ, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b0, "ldw_after_abort"));
    @(negedge clk);

    // Reset mid-WAIT during a write: write is lost.
    en[0] = 1'b1; we[0] = WE_WORD; addr[0] = 16'h0020; din[0] = 16'h5555;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_r", r[0], 1'b0);
    check("rst_wait_state", 32'(u_w4.state), 32'(IDLE));
    en[0] = 1'b0; we[0] = WE_READ;
    clear_models();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(v(0, WE_READ, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b0, "ldw_after_rst"));
    @(negedge clk);

    // Reset while dcache_r is high drops it at once.
    push_exp(1, 16'hC0DE, 1'b0);
    en[1] = 1'b1; we[1] = WE_READ; addr[1] = 16'h0002;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_r_high", r[1], 1'b1);
    en[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_r", r[1], 1'b0);
    check("rst_async_dout", dout[1], 16'h0000);
    check("rst_async_state", 32'(u_w0.state), 32'(IDLE));
    clear_models();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef LC3BP_DMEM_STATS_EN
    access(v(0, WE_READ, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b0, "st_rd1"));
    access(v(0, WE_READ, 16'h0010, 16'h0000, 16'h12EF, 1'b0, 1'b0, "st_rd2"));
    access(v(0, WE_WORD, 16'h0040, 16'h0101, 16'h0000, 1'b0, 1'b0, "st_wr1"));
    access(v(0, WE_READ, 16'h0800, 16'h0000, 16'h0000, 1'b1, 1'b0, "st_rd3_oor"));
    en[0] = 1'b1; we[0] = WE_WORD; addr[0] = 16'h0042; din[0] = 16'h0202;
    @(posedge clk);
    @(negedge clk);
    en[0] = 1'b0; we[0] = WE_READ;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rd_count_%0d", k), rd_cnt[k], rd_model[k][15:0]);
      check($sformatf("wr_count_%0d", k), wr_cnt[k], wr_model[k][15:0]);
    end
    force u_w0.rd_count = 16'hFFFF;
    @(negedge clk);
    release u_w0.rd_count;
    rd_model[1] = 16'hFFFF;
    access(v(1, WE_READ, 16'h0002, 16'h0000, 16'hC0DE, 1'b0, 1'b0, "st_sat"));
    @(negedge clk);
    check("rd_count_sat", rd_cnt[1], 16'hFFFF);
    check("wr_count_sat_side", wr_cnt[1], wr_model[1][15:0]);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
